// File: rtl/prog_sequencer.sv
// Program sequencer for the 9-bit 3BC processor: PC, Start/Ack handshake, one-cycle load wait.
// Optional executed-cycle counter on the Cycles port when SEQ_CYCLE_COUNT_EN is defined.
module prog_sequencer #(
  parameter int          PC_W     = 10,
  parameter int unsigned START_PC = 0
`ifdef SEQ_CYCLE_COUNT_EN
  , parameter int        CNT_W    = 16
`endif
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic [8:0]      Instruction,
  input  logic            IsLoad,
  input  logic            Jump,
  input  logic [PC_W-1:0] JumpTarget,
  output logic [PC_W-1:0] PC,
  output logic            ExecEn,
  output logic            Ack
`ifdef SEQ_CYCLE_COUNT_EN
  , output logic [CNT_W-1:0] Cycles
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    LDWAIT = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [8:0] HALT_INSTR = 9'h1FF;

  state_t state;
  logic   halt;

  assign halt = (Instruction == HALT_INSTR);

  // Halt and load both suppress commit in RUN; the load commits one cycle later in LDWAIT.
  always_comb begin
    ExecEn = 1'b0;
    case (state)
      RUN:     ExecEn = !halt && !IsLoad;
      LDWAIT:  ExecEn = 1'b1;
      default: ExecEn = 1'b0;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      PC    <= '0;
      Ack   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            state <= RUN;
            PC    <= PC_W'(START_PC);
          end
        end
        RUN: begin
          if (halt) begin
            state <= DONE;
            Ack   <= 1'b1;
          end else if (IsLoad) begin
            state <= LDWAIT;
          end else if (Jump) begin
            PC <= JumpTarget;
          end else begin
            PC <= PC + PC_W'(1);
          end
        end
        LDWAIT: begin
          state <= RUN;
          PC    <= PC + PC_W'(1);
        end
        DONE: begin
          if (!Start) begin
            state <= IDLE;
            Ack   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SEQ_CYCLE_COUNT_EN
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Cycles <= '0;
    end else if (state == IDLE && Start) begin
      Cycles <= '0;
    end else if ((state == RUN || state == LDWAIT) && Cycles != '1) begin
      Cycles <= Cycles + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed bench for prog_sequencer (PC_W=4, START_PC=2) with a small ROM model driving decode inputs.
module tb_prog_sequencer;

  localparam int PW = 4;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          Start;
  logic [8:0]    Instruction;
  logic          IsLoad;
  logic          Jump;
  logic [PW-1:0] JumpTarget;
  logic [PW-1:0] PC;
  logic          ExecEn;
  logic          Ack;
`ifdef SEQ_CYCLE_COUNT_EN
  logic [15:0]   Cycles;
`endif

  int checks   = 0;
  int failures = 0;

  logic [8:0]    rom_instr [16];
  logic          rom_load  [16];
  logic          rom_jump  [16];
  logic [PW-1:0] rom_tgt   [16];

  assign Instruction = rom_instr[PC];
  assign IsLoad      = rom_load[PC];
  assign Jump        = rom_jump[PC];
  assign JumpTarget  = rom_tgt[PC];

  prog_sequencer #(.PC_W(PW), .START_PC(2)) dut (
    .Clk(Clk),
    .Reset(Reset),
    .Start(Start),
    .Instruction(Instruction),
    .IsLoad(IsLoad),
    .Jump(Jump),
    .JumpTarget(JumpTarget),
    .PC(PC),
    .ExecEn(ExecEn),
    .Ack(Ack)
`ifdef SEQ_CYCLE_COUNT_EN
    , .Cycles(Cycles)
`endif
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic          rst;
    logic          st;
    logic [PW-1:0] pc;
    logic          en;
    logic          ack;
  } vec_t;

  vec_t tbl [18];

  task automatic rom_clear();
    for (int i = 0; i < 16; i++) begin
      rom_instr[i] = 9'h000;
      rom_load[i]  = 1'b0;
      rom_jump[i]  = 1'b0;
      rom_tgt[i]   = '0;
    end
  endtask

  task automatic rom_set(input int a, input logic [8:0] ins, input logic ld, input logic jp,
                         input logic [PW-1:0] tg);
    rom_instr[a] = ins;
    rom_load[a]  = ld;
    rom_jump[a]  = jp;
    rom_tgt[a]   = tg;
  endtask

  // Apply Reset/Start for one cycle; outputs observed are those produced by the previous edge.
  task automatic step(input logic rst, input logic st, input logic [PW-1:0] pc,
                      input logic en, input logic ack, input string nm);
    @(negedge Clk);
    Reset = rst;
    Start = st;
    #1;
    checks++;
    if (PC !== pc) begin
      failures++;
      $display("FAIL %s pc got=%h exp=%h", nm, PC, pc);
    end
    checks++;
    if (ExecEn !== en) begin
      failures++;
      $display("FAIL %s execen got=%b exp=%b", nm, ExecEn, en);
    end
    checks++;
    if (Ack !== ack) begin
      failures++;
      $display("FAIL %s ack got=%b exp=%b", nm, Ack, ack);
    end
  endtask

  task automatic check_cycles(input int exp, input string nm);
`ifdef SEQ_CYCLE_COUNT_EN
    checks++;
    if (Cycles !== 16'(exp)) begin
      failures++;
      $display("FAIL %s cycles got=%0d exp=%0d", nm, Cycles, exp);
    end
`else
    if (exp < 0) $display("unexpected cycle target %0d for %s", exp, nm);
`endif
  endtask

  initial begin
    for (int i = 0; i < 10; i++) tbl[i] = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 4'h0, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 4'h2, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 4'h3, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 4'h4, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 1'b1, 4'h5, 1'b1, 1'b0};
    tbl[15] = '{1'b0, 1'b1, 4'h6, 1'b0, 1'b0};
    tbl[16] = '{1'b0, 1'b1, 4'h6, 1'b0, 1'b1};
    tbl[17] = '{1'b0, 1'b0, 4'h6, 1'b0, 1'b1};

    rom_clear();
    rom_set(2, 9'h011, 1'b0, 1'b0, 4'h0);
    rom_set(3, 9'h022, 1'b0, 1'b0, 4'h0);
    rom_set(4, 9'h033, 1'b0, 1'b0, 4'h0);
    rom_set(5, 9'h044, 1'b0, 1'b0, 4'h0);
    rom_set(6, 9'h1FF, 1'b0, 1'b0, 4'h0);

    Reset = 1'b1;
    Start = 1'b0;
    repeat (2) @(posedge Clk);

    // Idle after reset, then straight-line program 2..5 with halt at 6
    for (int i = 0; i < 18; i++) begin
      step(tbl[i].rst, tbl[i].st, tbl[i].pc, tbl[i].en, tbl[i].ack, $sformatf("vec%0d", i));
      if (i == 16) check_cycles(5, "straight_cycles");
    end
    step(1'b0, 1'b0, 4'h6, 1'b0, 1'b0, "ack_release");

    // Load stall: load at 4 also has Jump set (load wins, LDWAIT ignores jump); Start drops mid-run
    rom_clear();
    rom_set(4, 9'h0A5, 1'b1, 1'b1, 4'hA);
    rom_set(6, 9'h1FF, 1'b0, 1'b0, 4'h0);
    step(1'b0, 1'b1, 4'h6, 1'b0, 1'b0, "ld_start");
    step(1'b0, 1'b0, 4'h2, 1'b1, 1'b0, "ld_pc2");
    step(1'b0, 1'b0, 4'h3, 1'b1, 1'b0, "ld_pc3");
    step(1'b0, 1'b0, 4'h4, 1'b0, 1'b0, "ld_run");
    step(1'b0, 1'b0, 4'h4, 1'b1, 1'b0, "ld_wait");
    step(1'b0, 1'b0, 4'h5, 1'b1, 1'b0, "ld_pc5");
    step(1'b0, 1'b0, 4'h6, 1'b0, 1'b0, "ld_halt");
    step(1'b0, 1'b0, 4'h6, 1'b0, 1'b1, "ld_done");
    check_cycles(6, "ld_cycles");
    step(1'b0, 1'b0, 4'h6, 1'b0, 1'b0, "ld_idle");

    // Jump to all-ones then wrap to 0; halt at 1 carries IsLoad and Jump (halt wins)
    rom_clear();
    rom_set(2,  9'h055, 1'b0, 1'b1, 4'hF);
    rom_set(15, 9'h066, 1'b0, 1'b0, 4'h0);
    rom_set(0,  9'h077, 1'b0, 1'b0, 4'h0);
    rom_set(1,  9'h1FF, 1'b1, 1'b1, 4'h5);
    step(1'b0, 1'b1, 4'h6, 1'b0, 1'b0, "jw_start");
    step(1'b0, 1'b1, 4'h2, 1'b1, 1'b0, "jw_jump");
    step(1'b0, 1'b1, 4'hF, 1'b1, 1'b0, "jw_pcF");
    step(1'b0, 1'b1, 4'h0, 1'b1, 1'b0, "jw_wrap");
    step(1'b0, 1'b1, 4'h1, 1'b0, 1'b0, "jw_halt");
    step(1'b0, 1'b1, 4'h1, 1'b0, 1'b1, "jw_hold");
    check_cycles(4, "jw_cycles");
    step(1'b0, 1'b0, 4'h1, 1'b0, 1'b1, "jw_drop");
    step(1'b0, 1'b0, 4'h1, 1'b0, 1'b0, "jw_idle");

    // Reset while in LDWAIT, then a clean re-run
    rom_clear();
    rom_set(3, 9'h0C3, 1'b1, 1'b0, 4'h0);
    rom_set(4, 9'h1FF, 1'b0, 1'b0, 4'h0);
    step(1'b0, 1'b1, 4'h1, 1'b0, 1'b0, "mr_start");
    step(1'b0, 1'b1, 4'h2, 1'b1, 1'b0, "mr_pc2");
    step(1'b0, 1'b1, 4'h3, 1'b0, 1'b0, "mr_load");
    step(1'b1, 1'b1, 4'h3, 1'b1, 1'b0, "mr_rst");
    step(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, "mr_after");
    check_cycles(0, "mr_cycles");
    step(1'b0, 1'b1, 4'h0, 1'b0, 1'b0, "mr_restart");
    step(1'b0, 1'b1, 4'h2, 1'b1, 1'b0, "mr2_pc2");
    step(1'b0, 1'b1, 4'h3, 1'b0, 1'b0, "mr2_load");
    step(1'b0, 1'b1, 4'h3, 1'b1, 1'b0, "mr2_wait");
    step(1'b0, 1'b1, 4'h4, 1'b0, 1'b0, "mr2_halt");
    step(1'b0, 1'b0, 4'h4, 1'b0, 1'b1, "mr2_done");
    check_cycles(4, "mr2_cycles");
    step(1'b0, 1'b0, 4'h4, 1'b0, 1'b0, "mr2_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prog_sequencer.md
# prog_sequencer

Multi-cycle program sequencer for the 9-bit 3BC processor. It owns the program counter, runs the Start/Ack handshake with the testbench, and inserts a one-cycle wait on data-memory loads. It produces the `ExecEn` qualifier that gates register-file and memory writes. It sits between the instruction ROM / decode logic and the fetch address, and replaces free-running PC logic with an explicit state machine.

## Interface
Parameters:
- `PC_W`, default 10: program counter width; instruction ROM depth is 2^PC_W.
- `START_PC`, default 0: PC value loaded when a program starts.
- `CNT_W`, default 16: width of the cycle counter (only with `SEQ_CYCLE_COUNT_EN`).

Ports:
- `Clk` — input, 1 bit: clock; all state updates on the rising edge.
- `Reset` — input, 1 bit: synchronous, active-high reset.
- `Start` — input, 1 bit: request to run a program; level-sensitive.
- `Instruction` — input, 9 bits: machine code at the current `PC`, combinational from the instruction ROM.
- `IsLoad` — input, 1 bit: decoded "current instruction reads data memory".
- `Jump` — input, 1 bit: decoded "branch taken" for the current instruction.
- `JumpTarget` — input, PC_W bits: absolute next PC when `Jump` is taken.
- `PC` — output, PC_W bits: registered fetch address.
- `ExecEn` — output, 1 bit: current instruction's writes (`RegWrEn`, `StoreInst`) may commit this cycle.
- `Ack` — output, 1 bit: program finished; registered (Moore).
- `Cycles` — output, CNT_W bits: executed-cycle count; present only with `SEQ_CYCLE_COUNT_EN`.

## Operation
States: IDLE, RUN, LDWAIT, DONE. Reset forces IDLE, `PC`=0, `Cycles`=0.

**IDLE** (`ExecEn`=0, `Ack`=0)
- `Start`=1: go to RUN, `PC` <= `START_PC`.
- Otherwise: hold.

**RUN** — decisions in priority order:
1. `Instruction` == 9'h1FF (halt): go to DONE. `PC` holds. `ExecEn`=0.
2. `IsLoad`=1: go to LDWAIT. `PC` holds. `ExecEn`=0. `Jump` is ignored.
3. Otherwise: `ExecEn`=1. `PC` <= `JumpTarget` if `Jump`, else `PC`+1. Stay in RUN.

**LDWAIT**
- `ExecEn`=1, so the load writeback commits with valid memory data.
- `PC` <= `PC`+1. Go to RUN. `Jump` is ignored.

**DONE** (`Ack`=1, `ExecEn`=0, `PC` holds)
- `Start`=0: go to IDLE.
- Otherwise: stay, so `Ack` stays high while `Start` is held.

**Arithmetic and boundaries**
- PC increment is modulo 2^PC_W; all-ones wraps to 0 with no flag.
- `Start` is ignored in RUN and LDWAIT.
- A `Start` deassertion mid-program does not abort.
- `Reset` in any state returns to IDLE on the next edge, overriding every other condition.
- `Jump` and `IsLoad` together: the load wins.
- Halt with `IsLoad` or `Jump` asserted: halt wins.

## Timing
- `PC`, `Ack`, `Cycles` and the state are registered. `ExecEn` is combinational from the state and the current-cycle `Instruction`/`IsLoad`.
- Start latency: `Start` sampled high in IDLE at edge N; `PC`=`START_PC` and state RUN after edge N. The first instruction executes in cycle N+1.
- Non-load instruction: 1 cycle. Load: 2 cycles (RUN, then LDWAIT).
- Halt: fetched in RUN during cycle K; `Ack`=1 from cycle K+1.
- Ack release: `Start` sampled low in DONE at edge M; `Ack`=0 after edge M.
- Back-to-back programs: `Start` must be observed low for at least one edge in DONE before the next run.

## Configuration
Macro `SEQ_CYCLE_COUNT_EN`.

Defined:
- `Cycles` port exists.
- Cleared to 0 on the IDLE->RUN transition.
- Increments by 1 on every edge taken in RUN or LDWAIT, including the halt cycle.
- Saturates at 2^CNT_W-1.
- Frozen in DONE and IDLE; reset value 0.

Undefined:
- No counter logic and no `Cycles` port.
- All other behaviour is identical.

## Test plan
- **Reset/idle:** `Reset`=1 for 2 cycles, `Start`=0 -> `PC`=0, `Ack`=0, `ExecEn`=0, and they stay so for 10 cycles.
- **Straight line:** `Start`=1, program of 4 non-load instructions then 9'h1FF -> `PC` sequence 0,1,2,3,4; `ExecEn`=1 for 4 cycles; `Ack`=1 at cycle 6; `Cycles`=5. After `Start` drops, `Ack`=0 one edge later.
- **Load stall:** load at PC 2 -> `PC` holds 2 for 2 cycles; `ExecEn` reads 0 then 1; halt at PC 4 gives `Cycles`=6.
- **Jump and wrap:** `PC_W`=4, `Jump`=1, `JumpTarget`=4'hF, next instruction non-jump -> `PC` goes F then 0.
- **Priority:** `IsLoad`=1 with `Jump`=1 -> LDWAIT, then `PC`+1 (jump ignored). Halt encoding with `IsLoad`=1 -> DONE directly.
- **Mid-run reset:** `Reset` pulsed while in LDWAIT -> next cycle IDLE, `PC`=0, `Cycles`=0, `ExecEn`=0; a re-`Start` runs normally from `START_PC`.
